// File: rtl/add1p_arbiter.sv
// add1p_arbiter: round-robin scheduler in front of a shared two-stage,
// carry-split pipelined adder. Each accepted operation carries its requester
// ID down the pipeline, so results emerge three edges after acceptance,
// tagged with their owner.
//
// Optional feature macro: ADD1P_ARB_SAT_EN
//   defined   -> a carry out of the top bit saturates sum to all ones
//   undefined -> sum wraps modulo 2^WIDTH; ovf reports the carry either way
//
// Handshake: gnt[i] is a combinational, one-hot grant. An operation from
// requester i is accepted on a rising edge where gnt[i]=1. gnt is forced to
// zero while hold=1 or reset_n=0, so no accept can happen on a stalled or
// reset edge. There is no output back-pressure other than hold. hold freezes
// every register, so sum/sum_id/sum_valid/ovf simply repeat while it is high.
module add1p_arbiter #(
    parameter int N      = 4,
    parameter int IDW    = 2,
    parameter int WIDTH  = 19,
    parameter int WIDTH1 = 9,
    parameter int WIDTH2 = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   x_bus,
    input  logic [N*WIDTH-1:0]   y_bus,
    input  logic                 hold,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     sum,
    output logic [IDW-1:0]       sum_id,
    output logic                 sum_valid,
    output logic                 ovf,
    output logic [1:0]           in_flight
);

    // Round-robin pointer.
    logic [IDW-1:0]    ptr_q, ptr_d;

    // Stage 0: split operands, owner ID and valid.
    logic [WIDTH1-1:0] xl0_q, yl0_q;
    logic [WIDTH2-1:0] xm0_q, ym0_q;
    logic [IDW-1:0]    id0_q;
    logic              v0_q, v0_d;

    // Stage 1: independent segment sums, each with its own carry bit.
    logic [WIDTH1:0]   r1_q, r1_d;
    logic [WIDTH2:0]   r2_q, r2_d;
    logic [IDW-1:0]    id1_q;
    logic              v1_q;

    // Stage 2: assembled result.
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDW-1:0]    sum_id_q;
    logic              sum_valid_q;
    logic              ovf_q, ovf_d;
    logic [1:0]        in_flight_q, in_flight_d;

    // Arbiter search results.
    logic [N-1:0]      gnt_raw;
    logic [IDW-1:0]    gidx;
    logic              found;
    int                idx;

    // Operand selected by the current grant.
    logic [WIDTH-1:0]  x_sel, y_sel;
    logic [WIDTH2:0]   msb_tmp;

    // Find the first requester at or after ptr, wrapping modulo N.
    always_comb begin
        gnt_raw = '0;
        gidx    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = IDW'(idx);
            end
        end
        if (found) begin
            gnt_raw[gidx] = 1'b1;
        end
    end

    assign gnt   = (reset_n && !hold) ? gnt_raw : '0;
    assign x_sel = x_bus[gidx*WIDTH +: WIDTH];
    assign y_sel = y_bus[gidx*WIDTH +: WIDTH];

    // Next-state values for the pointer, the segment adders and the result stage.
    always_comb begin
        v0_d = |gnt;
        ptr_d = ptr_q;
        if (v0_d) begin
            ptr_d = (gidx == IDW'(N - 1)) ? '0 : gidx + IDW'(1);
        end
        r1_d    = {1'b0, xl0_q} + {1'b0, yl0_q};
        r2_d    = {1'b0, xm0_q} + {1'b0, ym0_q};
        msb_tmp = r2_q + {{WIDTH2{1'b0}}, r1_q[WIDTH1]};
        ovf_d   = msb_tmp[WIDTH2];
        sum_d   = {msb_tmp[WIDTH2-1:0], r1_q[WIDTH1-1:0]};
`ifdef ADD1P_ARB_SAT_EN
        if (ovf_d) begin
            sum_d = '1;
        end
`endif
        in_flight_d = {1'b0, v0_d} + {1'b0, v0_q} + {1'b0, v1_q};
    end

    // Pipeline and pointer registers: reset clears, hold freezes, otherwise advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            xl0_q       <= '0;
            yl0_q       <= '0;
            xm0_q       <= '0;
            ym0_q       <= '0;
            id0_q       <= '0;
            v0_q        <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            id1_q       <= '0;
            v1_q        <= 1'b0;
            sum_q       <= '0;
            sum_id_q    <= '0;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_flight_q <= '0;
        end else if (!hold) begin
            ptr_q       <= ptr_d;
            xl0_q       <= x_sel[WIDTH1-1:0];
            yl0_q       <= y_sel[WIDTH1-1:0];
            xm0_q       <= x_sel[WIDTH-1:WIDTH1];
            ym0_q       <= y_sel[WIDTH-1:WIDTH1];
            id0_q       <= gidx;
            v0_q        <= v0_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            id1_q       <= id0_q;
            v1_q        <= v0_q;
            sum_q       <= sum_d;
            sum_id_q    <= id1_q;
            sum_valid_q <= v1_q;
            ovf_q       <= ovf_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign sum       = sum_q;
    assign sum_id    = sum_id_q;
    assign sum_valid = sum_valid_q;
    assign ovf       = ovf_q;
    assign in_flight = in_flight_q;

endmodule

// File: tb/tb_add1p_arbiter.sv
// Directed plus random bench for add1p_arbiter. Expected results are queued
// when an accept is predicted and popped when the result should reach the
// output stage. Honours ADD1P_ARB_SAT_EN for the expected sum.
module tb_add1p_arbiter;
    localparam int N      = 4;
    localparam int IDW    = 2;
    localparam int WIDTH  = 19;
    localparam int WIDTH1 = 9;
    localparam int WIDTH2 = 10;
    localparam int EW     = IDW + 1 + WIDTH;

    logic                 clk;
    logic                 reset_n;
    logic [N-1:0]         req;
    logic [N*WIDTH-1:0]   x_bus;
    logic [N*WIDTH-1:0]   y_bus;
    logic                 hold;
    logic [N-1:0]         gnt;
    logic [WIDTH-1:0]     sum;
    logic [IDW-1:0]       sum_id;
    logic                 sum_valid;
    logic                 ovf;
    logic [1:0]           in_flight;

    add1p_arbiter #(.N(N), .IDW(IDW), .WIDTH(WIDTH), .WIDTH1(WIDTH1), .WIDTH2(WIDTH2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .x_bus(x_bus), .y_bus(y_bus),
        .hold(hold), .gnt(gnt), .sum(sum), .sum_id(sum_id), .sum_valid(sum_valid),
        .ovf(ovf), .in_flight(in_flight)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    cur;
    logic [WIDTH-1:0] xs[N];
    logic [WIDTH-1:0] ys[N];
    int               m_ptr;
    bit               m_v0, m_v1, m_v2;
    int               vectors;
    int               miscompares;

    function automatic logic [EW-1:0] mk_exp(input int id, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] s;
        full = {1'b0, x} + {1'b0, y};
        s    = full[WIDTH-1:0];
`ifdef ADD1P_ARB_SAT_EN
        if (full[WIDTH]) s = '1;
`endif
        return {IDW'(id), full[WIDTH], s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        xs[i] = x;
        ys[i] = y;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            xs[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            ys[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        end
    endtask

    // driver: apply one cycle of inputs, check the grant, clock, check outputs
    task automatic step(input logic [N-1:0] rq, input logic hd, input logic rn);
        logic [N-1:0] g_exp;
        int           gi;
        int           k_idx;
        req     = rq;
        hold    = hd;
        reset_n = rn;
        for (int i = 0; i < N; i++) begin
            x_bus[i*WIDTH +: WIDTH] = xs[i];
            y_bus[i*WIDTH +: WIDTH] = ys[i];
        end
        #1;
        g_exp = '0;
        gi    = -1;
        if (rn && !hd) begin
            for (int k = 0; k < N; k++) begin
                k_idx = (m_ptr + k) % N;
                if (gi < 0 && rq[k_idx]) gi = k_idx;
            end
        end
        if (gi >= 0) g_exp[gi] = 1'b1;
        chk("gnt", 32'(gnt), 32'(g_exp));
        @(posedge clk);
        #1;
        if (!rn) begin
            m_v0 = 0; m_v1 = 0; m_v2 = 0; m_ptr = 0;
            exp_q.delete();
            cur = '0;
        end else if (!hd) begin
            m_v2 = m_v1;
            if (m_v1) cur = exp_q.pop_front();
            m_v1 = m_v0;
            m_v0 = (gi >= 0);
            if (gi >= 0) begin
                exp_q.push_back(mk_exp(gi, xs[gi], ys[gi]));
                m_ptr = (gi + 1) % N;
            end
        end
        chk("sum_valid", 32'(sum_valid), 32'(m_v2));
        chk("in_flight", 32'(in_flight), 32'(int'(m_v0) + int'(m_v1) + int'(m_v2)));
        if (m_v2) begin
            chk("sum", 32'(sum), 32'(cur[WIDTH-1:0]));
            chk("sum_id", 32'(sum_id), 32'(cur[EW-1 -: IDW]));
            chk("ovf", 32'(ovf), 32'(cur[WIDTH]));
        end
        if (!rn) begin
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_sum_id", 32'(sum_id), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
        end
    endtask

    // directed sequence, then random traffic, then report
    initial begin
        vectors = 0; miscompares = 0;
        m_ptr = 0; m_v0 = 0; m_v1 = 0; m_v2 = 0; cur = '0;
        req = '0; hold = 1'b0; reset_n = 1'b0; x_bus = '0; y_bus = '0;
        rand_ops();

        // reset, with a request present to confirm gnt is held at zero
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);

        // single operation from requester 2
        set_op(2, 19'h00123, 19'h00456);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("t1_sum_const", 32'(sum), 32'h579);
        chk("t1_id_const", 32'(sum_id), 32'd2);
        step(4'b0000, 1'b0, 1'b1);

        // carry across the LSB/MSB segment boundary
        set_op(1, 19'h001FF, 19'h00001);
        step(4'b0010, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("carry_const", 32'(sum), 32'h200);
        step(4'b0000, 1'b0, 1'b1);

        // full load from ptr=0: grants 1,2,4,8,... with no gaps
        step(4'b0000, 1'b0, 1'b0);
        rand_ops();
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1);

        // overflow
        set_op(0, 19'h7FFFF, 19'h7FFFF);
        step(4'b0001, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
`ifdef ADD1P_ARB_SAT_EN
        chk("ovf_sum_const", 32'(sum), 32'h7FFFF);
`else
        chk("ovf_sum_const", 32'(sum), 32'h7FFFE);
`endif
        chk("ovf_const", 32'(ovf), 32'd1);
        step(4'b0000, 1'b0, 1'b1);

        // three in flight, then hold for two cycles
        rand_ops();
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        chk("hold_in_flight_const", 32'(in_flight), 32'd3);
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b1);

        // reset with three in flight: nothing stale may appear afterwards
        rand_ops();
        for (int i = 0; i < 3; i++) step(4'b0110, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        chk("rst_in_flight_const", 32'(in_flight), 32'd0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);

        // random mix of requests, holds and operands
        for (int i = 0; i < 60; i++) begin
            rand_ops();
            step(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 4) == 0), 1'b1);
        end
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
